// File: rtl/dyn_nmr_ctrl.sv
// Dynamic N-modular-redundancy controller for motor commands.
// Votes LANES redundant {speed, dir} lanes at a level (TMR/DMR/simplex/safe)
// chosen from per-lane health, and tracks lane health with persistence counters.
module dyn_nmr_ctrl #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned W        = 4,
    parameter int unsigned FAIL_TH  = 3,
    parameter int unsigned RECOV_TH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES*W-1:0]   lane_speed,
    input  logic [LANES*W-1:0]   lane_dir,
    input  logic [LANES-1:0]     lane_flt,
    input  logic [1:0]           mode,
    output logic [W-1:0]         speed_o,
    output logic [W-1:0]         dir_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic [1:0]           active_o,
    output logic [LANES-1:0]     health_o
);

    localparam int unsigned WW     = 2 * W;
    localparam int unsigned TH_MAX = (FAIL_TH > RECOV_TH) ? FAIL_TH : RECOV_TH;
    localparam int unsigned CW     = $clog2(TH_MAX + 1);
    localparam int unsigned IW     = $clog2(LANES);
    localparam int unsigned HCW    = $clog2(LANES + 1);

    // Encoding doubles as the number of lanes the level consumes
    typedef enum logic [1:0] {
        LVL_SAFE    = 2'd0,
        LVL_SIMPLEX = 2'd1,
        LVL_DMR     = 2'd2,
        LVL_TMR     = 2'd3
    } level_t;

    typedef enum logic {
        ST_FAILED  = 1'b0,
        ST_HEALTHY = 1'b1
    } hstate_t;

    hstate_t          r_hst [LANES];
    logic [CW-1:0]    r_cnt [LANES];

    logic [WW-1:0]    w_word [LANES];
    logic [LANES-1:0] w_health;
    logic [HCW-1:0]   w_hcnt;
    level_t           w_level;
    logic [1:0]       w_nreq;
    logic [1:0]       w_nsel;
    logic [LANES-1:0] w_sel;
    logic [IW-1:0]    w_i0, w_i1, w_i2;
    logic [WW-1:0]    w_wa, w_wb, w_wc;
    logic [WW-1:0]    w_maj;
    logic             w_maj_ok;
    logic [WW-1:0]    w_vote_word;
    logic             w_vote_ok;
    logic [LANES-1:0] w_bad;

    // Unpack lane words and expose registered health
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_word[i]   = {lane_speed[i*W +: W], lane_dir[i*W +: W]};
            w_health[i] = (r_hst[i] == ST_HEALTHY);
        end
        health_o = w_health;
    end

    // Redundancy level from healthy-lane count and requested mode
    always_comb begin
        w_hcnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hcnt = w_hcnt + HCW'(w_health[i]);
        end
        w_level = LVL_SAFE;
        if (mode == 2'd3) begin
            if (w_hcnt >= HCW'(3))      w_level = LVL_TMR;
            else if (w_hcnt == HCW'(2)) w_level = LVL_DMR;
            else if (w_hcnt == HCW'(1)) w_level = LVL_SIMPLEX;
            else                        w_level = LVL_SAFE;
        end else if (32'(w_hcnt) > 32'(mode)) begin
            w_level = level_t'(mode + 2'd1);
        end
        w_nreq = 2'(w_level);
    end

    // Pick the lowest-index healthy lanes for the vote
    always_comb begin
        w_nsel = '0;
        w_sel  = '0;
        w_i0   = '0;
        w_i1   = '0;
        w_i2   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_health[i] && (w_nsel < w_nreq)) begin
                w_sel[i] = 1'b1;
                case (w_nsel)
                    2'd0:    w_i0 = IW'(i);
                    2'd1:    w_i1 = IW'(i);
                    default: w_i2 = IW'(i);
                endcase
                w_nsel = w_nsel + 2'd1;
            end
        end
        w_wa = w_word[w_i0];
        w_wb = w_word[w_i1];
        w_wc = w_word[w_i2];
    end

    // Majority of three and per-level vote result
    always_comb begin
        w_maj_ok = 1'b1;
        w_maj    = w_wa;
        if ((w_wa == w_wb) || (w_wa == w_wc)) begin
            w_maj = w_wa;
        end else if (w_wb == w_wc) begin
            w_maj = w_wb;
        end else begin
            w_maj_ok = 1'b0;
        end
        w_vote_word = w_wa;
        w_vote_ok   = 1'b0;
        case (w_level)
            LVL_TMR: begin
                w_vote_word = w_maj;
                w_vote_ok   = w_maj_ok;
            end
            LVL_DMR:     w_vote_ok = (w_wa == w_wb);
            LVL_SIMPLEX: w_vote_ok = 1'b1;
            default:     w_vote_ok = 1'b0;
        endcase
    end

    // Per-lane bad flag; only a TMR minority lane is blamed for its word
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_bad[i] = lane_flt[i] |
                       ((w_level == LVL_TMR) && w_sel[i] && w_maj_ok && (w_word[i] != w_maj));
        end
    end

    // Per-lane health FSM with persistence counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_hst[i] <= ST_HEALTHY;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                case (r_hst[i])
                    ST_HEALTHY: begin
                        if (!w_bad[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] >= CW'(FAIL_TH - 1)) begin
                            r_hst[i] <= ST_FAILED;
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CW'(1);
                        end
                    end
                    default: begin
                        if (w_bad[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] >= CW'(RECOV_TH - 1)) begin
                            r_hst[i] <= ST_HEALTHY;
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Registered voted outputs; hold the last word on disagreement
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_o  <= '0;
            dir_o    <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            active_o <= 2'd0;
        end else begin
            active_o <= 2'(w_level);
            if (w_level == LVL_SAFE) begin
                speed_o <= '0;
                valid_o <= 1'b0;
                err_o   <= 1'b1;
            end else if (w_vote_ok) begin
                speed_o <= w_vote_word[WW-1:W];
                dir_o   <= w_vote_word[W-1:0];
                valid_o <= 1'b1;
                err_o   <= 1'b0;
            end else begin
                valid_o <= 1'b0;
                err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dyn_nmr_ctrl.sv
// Self-checking bench for dyn_nmr_ctrl: directed table, corner sequences,
// and randomized stimulus against a behavioural model.
module tb_dyn_nmr_ctrl;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 4;
    localparam int FAIL_TH  = 3;
    localparam int RECOV_TH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      lane_speed, lane_dir;
    logic [3:0]       lane_flt;
    logic [1:0]       mode;
    logic [3:0]       speed_o, dir_o;
    logic             valid_o, err_o;
    logic [1:0]       active_o;
    logic [3:0]       health_o;

    dyn_nmr_ctrl #(.LANES(LANES), .W(W), .FAIL_TH(FAIL_TH), .RECOV_TH(RECOV_TH)) dut (
        .clk(clk), .rst(rst),
        .lane_speed(lane_speed), .lane_dir(lane_dir), .lane_flt(lane_flt), .mode(mode),
        .speed_o(speed_o), .dir_o(dir_o), .valid_o(valid_o), .err_o(err_o),
        .active_o(active_o), .health_o(health_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] es, input logic [3:0] ed,
                             input logic ev, input logic ee, input logic [1:0] ea,
                             input logic [3:0] eh);
        chk({tag, ".speed"},  32'(speed_o),  32'(es));
        chk({tag, ".dir"},    32'(dir_o),    32'(ed));
        chk({tag, ".valid"},  32'(valid_o),  32'(ev));
        chk({tag, ".err"},    32'(err_o),    32'(ee));
        chk({tag, ".active"}, 32'(active_o), 32'(ea));
        chk({tag, ".health"}, 32'(health_o), 32'(eh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_h   [4];
    int         m_cnt [4];
    logic [3:0] m_spd, m_dir;
    logic       m_v, m_e;
    logic [1:0] m_act;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_h[i]   = 1'b1;
            m_cnt[i] = 0;
        end
        m_spd = '0; m_dir = '0; m_v = 1'b0; m_e = 1'b0; m_act = '0;
    endfunction

    function automatic logic [3:0] model_health();
        logic [3:0] h;
        for (int i = 0; i < 4; i++) h[i] = m_h[i];
        return h;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_edge();
        int  hc, lvl, maj, c;
        int  words [4];
        int  sel [$];
        bit  found, bad, in_sel;
        logic [7:0] mw;
        hc = 0;
        for (int i = 0; i < 4; i++) begin
            words[i] = int'({lane_speed[i*4 +: 4], lane_dir[i*4 +: 4]});
            hc += int'(m_h[i]);
        end
        if (mode == 2'd3) lvl = (hc > 3) ? 3 : hc;
        else              lvl = (hc >= int'(mode) + 1) ? int'(mode) + 1 : 0;
        for (int i = 0; i < 4; i++)
            if (m_h[i] && sel.size() < lvl) sel.push_back(i);
        found = 1'b0;
        maj   = 0;
        foreach (sel[a]) begin
            c = 0;
            foreach (sel[b]) if (words[sel[b]] == words[sel[a]]) c++;
            if (2 * c > sel.size()) begin
                found = 1'b1;
                maj   = words[sel[a]];
            end
        end
        m_act = 2'(lvl);
        if (lvl == 0) begin
            m_spd = '0; m_v = 1'b0; m_e = 1'b1;
        end else if (found) begin
            mw = 8'(maj);
            m_spd = mw[7:4]; m_dir = mw[3:0]; m_v = 1'b1; m_e = 1'b0;
        end else begin
            m_v = 1'b0; m_e = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            in_sel = 1'b0;
            foreach (sel[k]) if (sel[k] == i) in_sel = 1'b1;
            bad = lane_flt[i] || (lvl == 3 && in_sel && found && words[i] != maj);
            if (m_h[i]) begin
                if (bad) begin
                    m_cnt[i]++;
                    if (m_cnt[i] >= FAIL_TH) begin m_h[i] = 1'b0; m_cnt[i] = 0; end
                end else m_cnt[i] = 0;
            end else begin
                if (!bad) begin
                    m_cnt[i]++;
                    if (m_cnt[i] >= RECOV_TH) begin m_h[i] = 1'b1; m_cnt[i] = 0; end
                end else m_cnt[i] = 0;
            end
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [15:0] spd;
        logic [15:0] dir;
        logic [3:0]  flt;
        logic [3:0]  e_spd;
        logic [3:0]  e_dir;
        logic        e_v;
        logic        e_e;
        logic [1:0]  e_act;
        logic [3:0]  e_h;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [1:0] md, input logic [15:0] s, input logic [15:0] d,
                                input logic [3:0] f, input logic [3:0] es, input logic [3:0] ed,
                                input logic ev, input logic ee, input logic [1:0] ea,
                                input logic [3:0] eh);
        vec_t v;
        v.mode = md; v.spd = s; v.dir = d; v.flt = f;
        v.e_spd = es; v.e_dir = ed; v.e_v = ev; v.e_e = ee; v.e_act = ea; v.e_h = eh;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        mode = 2'd3; lane_speed = 16'hAAAA; lane_dir = 16'h5555; lane_flt = 4'h0;
        #12;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    bit         r_bad_lane [4];
    bit         r_flt_lane [4];
    logic [3:0] base_s, base_d;

    initial begin
        // all lanes agree, auto mode -> TMR
        tbl[0] = mk(2'd3, 16'hAAAA, 16'h5555, 4'h0, 4'hA, 4'h5, 1, 0, 2'd3, 4'hF);
        // forced TMR, lane1 disagrees: three bad cycles then lane1 fails
        tbl[1] = mk(2'd2, 16'hAA7A, 16'h5555, 4'h0, 4'hA, 4'h5, 1, 0, 2'd3, 4'hF);
        tbl[2] = mk(2'd2, 16'hAA7A, 16'h5555, 4'h0, 4'hA, 4'h5, 1, 0, 2'd3, 4'hF);
        tbl[3] = mk(2'd2, 16'hAA7A, 16'h5555, 4'h0, 4'hA, 4'h5, 1, 0, 2'd3, 4'hD);
        tbl[4] = mk(2'd2, 16'hAA7A, 16'h5555, 4'h0, 4'hA, 4'h5, 1, 0, 2'd3, 4'hD);
        // auto, flags on lanes 0..2 for three cycles -> only lane3 left
        tbl[5] = mk(2'd3, 16'hAAAA, 16'h5555, 4'h7, 4'hA, 4'h5, 1, 0, 2'd3, 4'hD);
        tbl[6] = mk(2'd3, 16'hAAAA, 16'h5555, 4'h7, 4'hA, 4'h5, 1, 0, 2'd3, 4'hD);
        tbl[7] = mk(2'd3, 16'hAAAA, 16'h5555, 4'h7, 4'hA, 4'h5, 1, 0, 2'd3, 4'h8);
        tbl[8] = mk(2'd3, 16'hCAAA, 16'h3555, 4'h7, 4'hC, 4'h3, 1, 0, 2'd1, 4'h8);
        // forced DMR with one healthy lane -> SAFE, dir held
        tbl[9] = mk(2'd1, 16'hCAAA, 16'h3555, 4'h0, 4'h0, 4'h3, 0, 1, 2'd0, 4'h8);

        do_reset();
        check_out("reset", 4'h0, 4'h0, 0, 0, 2'd0, 4'hF);

        for (int k = 0; k < NV; k++) begin
            mode = tbl[k].mode; lane_speed = tbl[k].spd; lane_dir = tbl[k].dir;
            lane_flt = tbl[k].flt;
            tick();
            check_out($sformatf("vec%0d", k), tbl[k].e_spd, tbl[k].e_dir, tbl[k].e_v,
                      tbl[k].e_e, tbl[k].e_act, tbl[k].e_h);
        end

        // DMR disagreement holds outputs and blames nobody
        do_reset();
        mode = 2'd1;
        tick();
        check_out("dmr_agree", 4'hA, 4'h5, 1, 0, 2'd2, 4'hF);
        lane_speed = 16'hAA9A;
        tick();
        check_out("dmr_split1", 4'hA, 4'h5, 0, 1, 2'd2, 4'hF);
        repeat (19) tick();
        check_out("dmr_split20", 4'hA, 4'h5, 0, 1, 2'd2, 4'hF);

        // all lanes flagged -> SAFE, then recovery after RECOV_TH clean cycles
        do_reset();
        mode = 2'd3;
        tick();
        lane_flt = 4'hF;
        repeat (3) tick();
        check_out("allflt3", 4'hA, 4'h5, 1, 0, 2'd3, 4'h0);
        tick();
        check_out("safe", 4'h0, 4'h5, 0, 1, 2'd0, 4'h0);
        lane_flt = 4'h0;
        repeat (7) tick();
        check_out("recov7", 4'h0, 4'h5, 0, 1, 2'd0, 4'h0);
        tick();
        check_out("recov8", 4'h0, 4'h5, 0, 1, 2'd0, 4'hF);
        tick();
        check_out("recov_tmr", 4'hA, 4'h5, 1, 0, 2'd3, 4'hF);

        // async reset mid-failure restarts lane1's bad count
        do_reset();
        mode = 2'd2; lane_speed = 16'hAA7A;
        tick();
        tick();
        chk("pre_rst.health", 32'(health_o), 32'hF);
        #2 rst = 1'b0;
        #1;
        check_out("async_rst", 4'h0, 4'h0, 0, 0, 2'd0, 4'hF);
        rst = 1'b1;
        tick();
        tick();
        check_out("post_rst2", 4'hA, 4'h5, 1, 0, 2'd3, 4'hF);
        tick();
        check_out("post_rst3", 4'hA, 4'h5, 1, 0, 2'd3, 4'hD);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 4; i++) begin r_bad_lane[i] = 0; r_flt_lane[i] = 0; end
        base_s = 4'hA; base_d = 4'h5;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                base_s = 4'($urandom); base_d = 4'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) r_bad_lane[i] = !r_bad_lane[i];
                if ($urandom_range(0, 19) == 0) r_flt_lane[i] = !r_flt_lane[i];
                lane_speed[i*4 +: 4] = r_bad_lane[i] ? 4'($urandom_range(0, 2)) : base_s;
                lane_dir[i*4 +: 4]   = r_bad_lane[i] ? 4'($urandom_range(0, 1)) : base_d;
                lane_flt[i]          = r_flt_lane[i];
            end
            model_edge();
            tick();
            check_out($sformatf("rnd%0d", n), m_spd, m_dir, m_v, m_e, m_act, model_health());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dyn_nmr_ctrl.md
Name: dyn_nmr_ctrl

Overview:
Parametrised successor to the fixed TMR motor-command controller. It takes LANES redundant {speed, dir} command lanes with per-lane fault flags and tracks each lane's health with persistence counters. It degrades or restores the redundancy level (TMR/DMR/simplex/safe) automatically or by forced mode, and drives a single voted, registered {speed_o, dir_o} to the motor driver stage.

Parameters:
LANES, 4, number of redundant lanes (>=3)
W, 4, width of each speed and dir field
FAIL_TH, 3, consecutive bad cycles before a lane is declared failed (>=1)
RECOV_TH, 8, consecutive good cycles before a failed lane is restored (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
lane_speed  in  LANES*W  lane i speed at [i*W +: W]
lane_dir  in  LANES*W  lane i dir at [i*W +: W]
lane_flt  in  LANES  per-lane fault flag, 1 = lane reports fault
mode  in  2  0 = simplex, 1 = DMR, 2 = TMR (forced), 3 = auto
speed_o  out  W  voted speed, registered
dir_o  out  W  voted dir, registered
valid_o  out  1  1 = outputs carry a voted/passed value this cycle
err_o  out  1  1 = vote failed (no agreement) or SAFE
active_o  out  2  active level: 0 SAFE, 1 SIMPLEX, 2 DMR, 3 TMR
health_o  out  LANES  1 = lane healthy

Behaviour:
- Single clock domain. Reset is asynchronous, active-low. While rst=0: speed_o=0, dir_o=0, valid_o=0, err_o=0, active_o=0, health_o=all 1s, all counters 0.
- Lane word = {speed, dir}. Comparisons use the full 2W-bit word.
- Selection is combinational from the registered health_o. The block uses the lowest-index healthy lanes.
  - Required count by mode: 1 for mode 0, 2 for mode 1, 3 for mode 2.
  - In auto mode, the level is TMR if >=3 lanes are healthy, DMR if 2, SIMPLEX if 1, and SAFE if 0.
  - In a forced mode with too few healthy lanes, the level is SAFE.
- Vote, per level:
  - TMR: output the majority word of the 3 selected lanes. If all 3 differ, no agreement.
  - DMR: output the common word if the 2 selected lanes are equal; otherwise no agreement.
  - SIMPLEX: pass the selected lane through.
  - SAFE: speed_o=0, dir_o holds its last value, valid_o=0, err_o=1.
- No agreement: speed_o and dir_o hold their previous values, valid_o=0, err_o=1. Otherwise valid_o=1 and err_o=0.
- Latency: exactly 1 clock. Inputs and mode sampled at edge t appear on the outputs after edge t. active_o is registered at the same edge.
- A lane is "bad" in a cycle if lane_flt[i]=1, or if the level is TMR, the lane is selected, a majority exists, and the lane's word differs from the majority.
  - DMR and simplex mismatches do not attribute blame.
  - Unselected healthy lanes are judged on lane_flt only.
- Per-lane health FSM:
  - States: HEALTHY (health_o[i]=1) and FAILED (health_o[i]=0).
  - Counter width is clog2(max(FAIL_TH,RECOV_TH)+1).
  - HEALTHY: the counter increments on a bad cycle and clears on a good one. When the count reaches FAIL_TH, go to FAILED and clear the counter.
  - FAILED: the counter increments on a good cycle and clears on a bad one. When the count reaches RECOV_TH, go to HEALTHY and clear the counter.
  - Counters saturate and never wrap.
- A health change at edge t affects lane selection from cycle t+1 onward; there is no combinational bypass.
- A mode change takes effect on the next edge. It does not reset the health counters.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

Test Plan:
(Defaults LANES=4, W=4, FAIL_TH=3, RECOV_TH=8.)
1. Reset, then mode=3, all lanes speed=10 dir=5, lane_flt=0 -> one clock after sampling: speed_o=10, dir_o=5, valid_o=1, err_o=0, active_o=3, health_o=4'b1111.
2. mode=2, lane1 speed=7 (others 10) -> speed_o=10 every cycle. After 3 clocks health_o=4'b1101 and lanes 0,2,3 are selected. speed_o stays 10 and err_o stays 0 throughout.
3. mode=3, lane_flt=4'b0111 held -> after 3 clocks health_o=4'b1000, active_o=1, outputs follow lane 3 (set lane3 speed=12 dir=3 -> speed_o=12, dir_o=3).
4. mode=1, lane_flt=0, lanes 0/1 words differ (10/5 vs 9/5) -> speed_o and dir_o hold their prior values, valid_o=0, err_o=1, health_o unchanged after 20 clocks.
5. lane_flt=4'b1111 in mode 3 -> after 3 clocks active_o=0, speed_o=0, dir_o held, valid_o=0, err_o=1. Then clear all flags -> after 8 clean clocks health_o=4'b1111 and active_o=3 on the next clock.
6. Assert rst low mid-scenario 2 (between edges) -> all outputs take their reset values immediately. After release, lane1 again needs 3 bad clocks to fail.
